// File: rtl/avg_enha_pkg.sv
// Shared constants and the storage word type for the averager-to-enhancement elastic buffer.
package avg_enha_pkg;

  localparam int unsigned LSUM_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CH_MAX     = 4;

  // Word at the default widths with the maximum channel count; the buffer
  // re-declares it at its actual parameter widths for the memory.
  typedef struct packed {
    logic [LSUM_W_DEF-1:0]        lineSum;
    logic [CH_MAX*DATA_W_DEF-1:0] blockData;
  } avg_enha_word_t;

endpackage

// File: rtl/avg_enha_fifo_mem.sv
// Storage behind the output register: ENTRIES-deep circular memory with
// wrapping pointers and empty/full tracking.
module avg_enha_fifo_mem
  import avg_enha_pkg::*;
#(
  parameter type         wordT   = avg_enha_word_t,
  parameter int unsigned ENTRIES = 3
) (
  input  logic iODCK,
  input  logic iRST,
  input  logic iFlush,
  input  logic iWr,
  input  logic iRd,
  input  wordT iWrData,
  output wordT oRdData,
  output logic oEmpty
);

  localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ENTRIES - 1);

  wordT             mem [ENTRIES];
  logic [PTR_W-1:0] wrPtrQ, rdPtrQ;
  logic [CNT_W-1:0] cntQ;
  logic             full, wrEn, rdEn;

  // Explicit wrap keeps non-power-of-2 depths correct; free for power-of-2.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cntQ == CNT_W'(ENTRIES));
  assign oEmpty  = (cntQ == '0);
  assign wrEn    = iWr & ~full & ~iFlush;
  assign rdEn    = iRd & ~oEmpty & ~iFlush;
  assign oRdData = mem[rdPtrQ];

  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else if (iFlush) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else begin
      if (wrEn) wrPtrQ <= ptrInc(wrPtrQ);
      if (rdEn) rdPtrQ <= ptrInc(rdPtrQ);
      if (wrEn && !rdEn) begin
        cntQ <= cntQ + CNT_W'(1);
      end else if (rdEn && !wrEn) begin
        cntQ <= cntQ - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iODCK) begin
    if (wrEn) mem[wrPtrQ] <= iWrData;
  end

endmodule

// File: rtl/avg_enha_elastic_buf.sv
// Valid/ready elastic buffer: registered output stage backed by a small FIFO,
// with occupancy, sticky overflow and synchronous frame flush.
module avg_enha_elastic_buf
  import avg_enha_pkg::*;
#(
  parameter  int unsigned LSUM_W = LSUM_W_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned CH     = 1,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                 iODCK,
  input  logic                 iRST,
  input  logic                 iFlush,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [LSUM_W-1:0]    iLineSum,
  input  logic [CH*DATA_W-1:0] iBlockData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [LSUM_W-1:0]    oLineSum,
  output logic [CH*DATA_W-1:0] oBlockData,
  output logic [LVL_W-1:0]     oLevel,
  output logic                 oOvf
);

  typedef struct packed {
    logic [LSUM_W-1:0]    lineSum;
    logic [CH*DATA_W-1:0] blockData;
  } wordT;

  wordT             outQ, outD, inWord, memHead;
  logic             validQ, validD, ovfQ, ovfD;
  logic [LVL_W-1:0] levelQ, levelD;
  logic             push, pop, memWr, memRd, memEmpty;

  // Ready depends on registered level only, so a pop cannot free a slot
  // for a push in the same cycle.
  assign oReady = (levelQ < LVL_W'(DEPTH));
  assign push   = iValid & oReady;
  assign pop    = validQ & iReady;
  assign inWord = '{lineSum: iLineSum, blockData: iBlockData};

  always_comb begin
    outD   = outQ;
    validD = validQ;
    levelD = levelQ;
    ovfD   = ovfQ;
    memWr  = 1'b0;
    memRd  = 1'b0;
    if (iFlush) begin
      outD   = '0;
      validD = 1'b0;
      levelD = '0;
      ovfD   = 1'b0;
    end else begin
      if (iValid && !oReady) ovfD = 1'b1;
      if (push && (!validQ || (pop && memEmpty))) begin
        outD   = inWord;
        validD = 1'b1;
      end else if (push) begin
        memWr = 1'b1;
        if (pop) begin
          memRd = 1'b1;
          outD  = memHead;
        end
      end else if (pop) begin
        if (memEmpty) begin
          validD = 1'b0;
        end else begin
          memRd = 1'b1;
          outD  = memHead;
        end
      end
      if (push && !pop) begin
        levelD = levelQ + LVL_W'(1);
      end else if (pop && !push) begin
        levelD = levelQ - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      outQ   <= '0;
      validQ <= 1'b0;
      levelQ <= '0;
      ovfQ   <= 1'b0;
    end else begin
      outQ   <= outD;
      validQ <= validD;
      levelQ <= levelD;
      ovfQ   <= ovfD;
    end
  end

  avg_enha_fifo_mem #(
    .wordT  (wordT),
    .ENTRIES(DEPTH - 1)
  ) uMem (
    .iODCK  (iODCK),
    .iRST   (iRST),
    .iFlush (iFlush),
    .iWr    (memWr),
    .iRd    (memRd),
    .iWrData(inWord),
    .oRdData(memHead),
    .oEmpty (memEmpty)
  );

  assign oValid     = validQ;
  assign oLineSum   = outQ.lineSum;
  assign oBlockData = outQ.blockData;
  assign oLevel     = levelQ;
  assign oOvf       = ovfQ;

endmodule

// File: tb/tb_avg_enha_elastic_buf.sv
// Directed bench for avg_enha_elastic_buf: default CH=1 instance plus a CH=3 instance.
module tb_avg_enha_elastic_buf;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush, valid, ready, rdy;
  logic [13:0] lineSum, oLs;
  logic [7:0]  blockData, oBd;
  logic        oVal, oOv;
  logic [2:0]  oLvl;

  logic        valid3, ready3, rdy3, oVal3, oOv3;
  logic [13:0] lineSum3, oLs3;
  logic [23:0] data3, oBd3, ob3;
  logic [2:0]  oLvl3;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  avg_enha_elastic_buf dut (
    .iODCK(clk), .iRST(rstN), .iFlush(flush), .iValid(valid), .oReady(rdy),
    .iLineSum(lineSum), .iBlockData(blockData), .oValid(oVal), .iReady(ready),
    .oLineSum(oLs), .oBlockData(oBd), .oLevel(oLvl), .oOvf(oOv)
  );

  avg_enha_elastic_buf #(.CH(3)) dut3 (
    .iODCK(clk), .iRST(rstN), .iFlush(1'b0), .iValid(valid3), .oReady(rdy3),
    .iLineSum(lineSum3), .iBlockData(data3), .oValid(oVal3), .iReady(ready3),
    .oLineSum(oLs3), .oBlockData(oBd3), .oLevel(oLvl3), .oOvf(oOv3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0;
    lineSum = '0; blockData = '0;
    valid3 = 1'b0; ready3 = 1'b0; lineSum3 = '0; data3 = '0;
    #1 rstN = 1'b0;
    #1;
    check("rst_valid", oVal, 0);
    check("rst_level", oLvl, 0);
    check("rst_ovf", oOv, 0);
    check("rst_lsum", oLs, 0);
    check("rst_data", oBd, 0);
    #7 rstN = 1'b1;
    #1;
    check("rst_ready", rdy, 1);
    step();

    // 1: pass-through latency
    valid = 1'b1; ready = 1'b1; lineSum = 14'h1234; blockData = 8'hA5;
    step();
    valid = 1'b0;
    check("t1_valid", oVal, 1);
    check("t1_lsum", oLs, 14'h1234);
    check("t1_data", oBd, 8'hA5);
    check("t1_level", oLvl, 1);
    step();
    check("t1_valid_fall", oVal, 0);
    check("t1_level0", oLvl, 0);
    check("t1_hold", oLs, 14'h1234);

    // 2: fill while stalled
    ready = 1'b0; valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      lineSum = 14'(i); blockData = 8'(8'h10 + i);
      step();
    end
    valid = 1'b0;
    check("t2_level", oLvl, 4);
    check("t2_ready", rdy, 0);
    check("t2_valid", oVal, 1);
    check("t2_head", oLs, 1);

    // 3: overflow drops the word
    valid = 1'b1; lineSum = 14'h0005; blockData = 8'hEE;
    step();
    valid = 1'b0;
    check("t3_ovf", oOv, 1);
    check("t3_level", oLvl, 4);
    check("t3_head", oLs, 1);
    ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      check("t3_drain_lsum", oLs, 32'(i));
      check("t3_drain_data", oBd, 32'(8'h10 + i));
      check("t3_drain_level", oLvl, 32'(5 - i));
    end
    step();
    check("t3_empty_valid", oVal, 0);
    check("t3_empty_level", oLvl, 0);
    check("t3_ovf_sticky", oOv, 1);

    // 4: steady push/pop at level 2 across pointer wrap
    ready = 1'b0; valid = 1'b1;
    lineSum = 14'h0100; step();
    lineSum = 14'h0101; step();
    check("t4_level_pre", oLvl, 2);
    check("t4_head_pre", oLs, 14'h0100);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      lineSum = 14'(14'h0102 + i);
      step();
      check("t4_lsum", oLs, 32'(14'h0101 + i));
      check("t4_level", oLvl, 2);
    end
    valid = 1'b0;
    step();
    check("t4_tail", oLs, 14'h0111);
    check("t4_tail_level", oLvl, 1);
    step();
    check("t4_drained", oVal, 0);

    // 5: flush overrides a simultaneous write
    ready = 1'b0; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lineSum = 14'(14'h0200 + i); blockData = 8'(8'h20 + i);
      step();
    end
    check("t5_level_pre", oLvl, 3);
    check("t5_ovf_pre", oOv, 1);
    flush = 1'b1; lineSum = 14'h3FFF; blockData = 8'hFF;
    step();
    flush = 1'b0; valid = 1'b0; ready = 1'b1;
    check("t5_level", oLvl, 0);
    check("t5_valid", oVal, 0);
    check("t5_ovf", oOv, 0);
    check("t5_lsum", oLs, 0);
    check("t5_data", oBd, 0);
    check("t5_ready", rdy, 1);
    step();
    check("t5_no_ghost", oVal, 0);
    check("t5_no_ghost_lvl", oLvl, 0);
    valid = 1'b1; lineSum = 14'h0ABC; blockData = 8'h5A;
    step();
    valid = 1'b0;
    check("t5_after_lsum", oLs, 14'h0ABC);
    check("t5_after_data", oBd, 8'h5A);
    check("t5_after_level", oLvl, 1);

    // 6: CH=3 channel order, then async reset between edges
    ready = 1'b0; valid = 1'b1; lineSum = 14'h0555; blockData = 8'h55;
    valid3 = 1'b1; lineSum3 = 14'h0777; data3 = 24'hC3B2A1;
    step();
    valid = 1'b0; valid3 = 1'b0;
    ob3 = oBd3;
    check("t6_ch3_word", ob3, 24'hC3B2A1);
    check("t6_ch3_c0", ob3[7:0], 8'hA1);
    check("t6_ch3_c2", ob3[23:16], 8'hC3);
    check("t6_ch3_lsum", oLs3, 14'h0777);
    check("t6_pre_level", oLvl, 2);
    #2 rstN = 1'b0;
    #1;
    check("t6_rst_valid", oVal, 0);
    check("t6_rst_level", oLvl, 0);
    check("t6_rst_lsum", oLs, 0);
    check("t6_rst_data", oBd, 0);
    check("t6_rst_ch3_data", oBd3, 0);
    check("t6_rst_ch3_valid", oVal3, 0);
    check("t6_rst_ch3_level", oLvl3, 0);
    #3 rstN = 1'b1;
    step();
    check("t6_post_ready", rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
